// File: rtl/alu.sv
// Single-cycle ALU: the operation result is formed combinationally from the
// operands and opcode, then captured into a result register on every clock.
module alu #(
    parameter int DATAWIDTH = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [DATAWIDTH-1:0] a_i,
    input  logic [DATAWIDTH-1:0] b_i,
    input  logic [3:0]           opcode_i,
    output logic [DATAWIDTH-1:0] out_o
);

    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_ADD  = 4'd1;
    localparam logic [3:0] OP_LW   = 4'd2;
    localparam logic [3:0] OP_SW   = 4'd3;
    localparam logic [3:0] OP_SUB  = 4'd4;
    localparam logic [3:0] OP_MUL  = 4'd5;
    localparam logic [3:0] OP_DIV  = 4'd6;
    localparam logic [3:0] OP_AND  = 4'd7;
    localparam logic [3:0] OP_OR   = 4'd8;
    localparam logic [3:0] OP_XOR  = 4'd9;
    localparam logic [3:0] OP_JMP  = 4'd10;
    localparam logic [3:0] OP_BEQ  = 4'd11;
    localparam logic [3:0] OP_BGT  = 4'd12;
    localparam logic [3:0] OP_BGE  = 4'd13;
    localparam logic [3:0] OP_ADDI = 4'd14;

    logic [DATAWIDTH-1:0] sum;
    logic [DATAWIDTH-1:0] diff;
    logic [DATAWIDTH-1:0] prod;
    logic [DATAWIDTH-1:0] quot;
    logic [DATAWIDTH-1:0] out_d;
    logic [DATAWIDTH-1:0] out_q;

    // Unrolled restoring division; one trial subtraction per quotient bit.
    function automatic logic [DATAWIDTH-1:0] udiv(
        input logic [DATAWIDTH-1:0] num,
        input logic [DATAWIDTH-1:0] den
    );
        logic [DATAWIDTH:0]   rem;
        logic [DATAWIDTH-1:0] q;
        rem = '0;
        q   = '0;
        for (int i = DATAWIDTH - 1; i >= 0; i--) begin
            rem = {rem[DATAWIDTH-1:0], num[i]};
            if (rem >= {1'b0, den}) begin
                rem  = rem - {1'b0, den};
                q[i] = 1'b1;
            end
        end
        return q;
    endfunction

    assign sum  = a_i + b_i;
    assign diff = a_i - b_i;
    assign prod = a_i * b_i;
    assign quot = udiv(a_i, b_i);

    // Address/branch-target opcodes all share the adder.
    always_comb begin
        out_d = '0;
        unique case (opcode_i)
            OP_NOP:  out_d = '0;
            OP_ADD, OP_LW, OP_SW, OP_JMP,
            OP_BEQ, OP_BGT, OP_BGE, OP_ADDI:
                     out_d = sum;
            OP_SUB:  out_d = diff;
            OP_MUL:  out_d = prod;
            OP_DIV:  out_d = (b_i == '0) ? '1 : quot;
            OP_AND:  out_d = a_i & b_i;
            OP_OR:   out_d = a_i | b_i;
            OP_XOR:  out_d = a_i ^ b_i;
            default: out_d = '0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_q <= '0;
        end else begin
            out_q <= out_d;
        end
    end

    assign out_o = out_q;

endmodule

// File: tb/tb_alu.sv
// Directed and randomized checks of the registered ALU against an
// arithmetic reference model.
module tb_alu;

    localparam int W = 32;

    logic         clk_i;
    logic         rst_ni;
    logic [W-1:0] a_i;
    logic [W-1:0] b_i;
    logic [3:0]   opcode_i;
    logic [W-1:0] out_o;

    int checks = 0;
    int errors = 0;

    alu #(.DATAWIDTH(W)) dut (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .a_i      (a_i),
        .b_i      (b_i),
        .opcode_i (opcode_i),
        .out_o    (out_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    function automatic logic [W-1:0] ref_model(
        input logic [3:0]   op,
        input logic [W-1:0] a,
        input logic [W-1:0] b
    );
        longint unsigned ua;
        longint unsigned ub;
        longint unsigned r;
        ua = 64'(a);
        ub = 64'(b);
        case (op)
            4'd1, 4'd2, 4'd3, 4'd10, 4'd11, 4'd12, 4'd13, 4'd14: r = ua + ub;
            4'd4:    r = ua + (64'd1 << W) - ub;
            4'd5:    r = ua * ub;
            4'd6:    r = (ub == 0) ? ((64'd1 << W) - 1) : ua / ub;
            4'd7:    r = ua & ub;
            4'd8:    r = ua | ub;
            4'd9:    r = ua ^ ub;
            default: r = 0;
        endcase
        return r[W-1:0];
    endfunction

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        opcode_i = op;
        a_i      = a;
        b_i      = b;
    endtask

    // Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.
    task automatic step(input string tag, input logic [3:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] exp);
        @(negedge clk_i);
        drive(op, a, b);
        @(posedge clk_i);
        #1;
        check(tag, out_o, exp);
    endtask

    logic [W-1:0] sweep_exp [16];
    logic [3:0]   rop;
    logic [W-1:0] ra;
    logic [W-1:0] rb;

    initial begin
        sweep_exp = '{32'd0, 32'd69, 32'd69, 32'd69, 32'hFFFFFFFF, 32'd1190, 32'd0, 32'd34,
                      32'd35, 32'd1, 32'd69, 32'd69, 32'd69, 32'd69, 32'd69, 32'd0};

        // Reset held low across clock edges
        rst_ni = 1'b0;
        drive(4'd1, 32'd34, 32'd35);
        #2;
        check("reset_initial", out_o, '0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk_i);
            #1;
            check($sformatf("reset_edge%0d", i), out_o, '0);
        end

        // First edge after deassertion loads the inputs present then
        @(negedge clk_i);
        rst_ni = 1'b1;
        #1;
        check("reset_released_no_edge", out_o, '0);
        @(posedge clk_i);
        #1;
        check("first_edge_after_reset", out_o, 32'd69);

        // Opcode sweep including the unassigned opcode
        for (int op = 0; op < 16; op++) begin
            step($sformatf("sweep_op%0d", op), 4'(op), 32'd34, 32'd35, sweep_exp[op]);
        end

        // Edge operands and divide-by-zero
        step("add_wrap",     4'd1, 32'hFFFFFFFF, 32'd1,       32'd0);
        step("mul_overflow", 4'd5, 32'h10000,    32'h10000,   32'd0);
        step("div_100_7",    4'd6, 32'd100,      32'd7,       32'd14);
        step("div_by_zero",  4'd6, 32'd5,        32'd0,       32'hFFFFFFFF);
        step("sub_zero",     4'd4, 32'd0,        32'd1,       32'hFFFFFFFF);
        step("div_max_max",  4'd6, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1);
        step("unassigned",   4'd15, 32'd34,      32'd35,      32'd0);

        // Mid-cycle opcode change must not reach out_o before the next edge
        step("latency_add", 4'd1, 32'd34, 32'd35, 32'd69);
        @(negedge clk_i);
        drive(4'd9, 32'd34, 32'd35);
        #1;
        check("latency_hold_mid", out_o, 32'd69);
        #3;
        check("latency_hold_late", out_o, 32'd69);
        @(posedge clk_i);
        #1;
        check("latency_xor", out_o, 32'd1);

        // Asynchronous reset between edges
        step("async_pre", 4'd1, 32'd34, 32'd35, 32'd69);
        #2;
        rst_ni = 1'b0;
        #1;
        check("async_clear_immediate", out_o, '0);
        @(posedge clk_i);
        #1;
        check("async_held_across_edge", out_o, '0);
        @(negedge clk_i);
        drive(4'd7, 32'hF0F0_1234, 32'hFF00_FF00);
        rst_ni = 1'b1;
        #1;
        check("async_released_no_edge", out_o, '0);
        @(posedge clk_i);
        #1;
        check("async_first_edge", out_o, 32'hF000_1200);

        // Randomized operations against the reference model
        for (int n = 0; n < 300; n++) begin
            rop = 4'($urandom_range(0, 15));
            ra  = $urandom;
            case ($urandom_range(0, 3))
                0:       rb = '0;
                1:       rb = W'($urandom_range(1, 255));
                default: rb = $urandom;
            endcase
            step($sformatf("rand%0d_op%0d", n, rop), rop, ra, rb, ref_model(rop, ra, rb));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
